mult_sequencer: RTL and testbench



---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_bit_counter.sv | 39 +++
 rtl/mult_sequencer.sv | 101 ++++++++++
 tb/tb_mult_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
package mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mult_bit_counter.sv
// Shifted-bit counter: clear/increment with a terminal flag one short of WIDTH.
module mult_bit_counter
    import mult_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_sequencer.sv
// Counted, handshaked controller for the shift-add multiplier datapath.
// Optional SKIP_ZERO_EN: a zero multiplier bit shifts straight from ADD.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          M,
    output logic          Load,
    output logic          Ad,
    output logic          Sh,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Count
);

    state_e        state_q;
    state_e        state_d;
    logic          load_c;
    logic          ad_c;
    logic          sh_c;
    logic          clr_c;
    logic          inc_c;
    logic [CW-1:0] cnt;
    logic          last;

    mult_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (clr_c),
        .inc   (inc_c),
        .cnt   (cnt),
        .last  (last)
    );

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        ad_c    = 1'b0;
        sh_c    = 1'b0;
        clr_c   = 1'b0;
        inc_c   = 1'b0;
        case (state_q)
            IDLE: begin
                load_c = Start;
                if (Start) begin
                    clr_c   = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
`ifdef SKIP_ZERO_EN
                if (M) begin
                    ad_c    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    sh_c    = 1'b1;
                    inc_c   = 1'b1;
                    state_d = last ? DONE : ADD;
                end
`else
                ad_c    = M;
                state_d = SHIFT;
`endif
            end
            SHIFT: begin
                sh_c    = 1'b1;
                inc_c   = 1'b1;
                state_d = last ? DONE : ADD;
            end
            DONE: begin
                // Held Start parks here; only a released Start rearms IDLE.
                if (!Start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset masks every output, including the Start-driven Load in IDLE.
    assign Load  = load_c & ~Reset;
    assign Ad    = ad_c & ~Reset;
    assign Sh    = sh_c & ~Reset;
    assign Busy  = ((state_q == ADD) || (state_q == SHIFT)) & ~Reset;
    assign Done  = (state_q == DONE) & ~Reset;
    assign Count = Reset ? '0 : cnt;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer at WIDTH=4 (directed) and WIDTH=8 (random).
module tb_mult_sequencer;

    localparam int unsigned W4  = 4;
    localparam int unsigned W8  = 8;
    localparam int unsigned CW4 = $clog2(W4 + 1);
    localparam int unsigned CW8 = $clog2(W8 + 1);

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic           start4, m4, load4, ad4, sh4, busy4, done4;
    logic [CW4-1:0] count4;
    logic           start8, m8, load8, ad8, sh8, busy8, done8;
    logic [CW8-1:0] count8;

    mult_sequencer #(.WIDTH(W4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(start4), .M(m4),
        .Load(load4), .Ad(ad4), .Sh(sh4), .Busy(busy4), .Done(done4), .Count(count4)
    );

    mult_sequencer #(.WIDTH(W8)) dut8 (
        .Clk(Clk), .Reset(Reset), .Start(start8), .M(m8),
        .Load(load8), .Ad(ad8), .Sh(sh8), .Busy(busy8), .Done(done8), .Count(count8)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] mult;
        int         exp_ad;
        int         exp_edges;
        int         hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic set_in(input int sel, input logic st, input logic m);
        if (sel == 8) begin
            start8 = st;
            m8     = m;
        end else begin
            start4 = st;
            m4     = m;
        end
    endtask

    task automatic get_out(input int sel, output logic ld, output logic ad, output logic sh,
                           output logic bs, output logic dn, output logic [31:0] cnt);
        if (sel == 8) begin
            ld = load8; ad = ad8; sh = sh8; bs = busy8; dn = done8; cnt = 32'(count8);
        end else begin
            ld = load4; ad = ad4; sh = sh4; bs = busy4; dn = done4; cnt = 32'(count4);
        end
    endtask

    // Runs one full operation; entered and left just after a rising edge with the DUT idle.
    task automatic run_op(input int sel, input logic [31:0] mult, input int unsigned w,
                          input int exp_ad, input int exp_edges, input int hold);
        logic [1:0]  q[$];
        logic [31:0] mreg;
        logic [31:0] cnt;
        logic        ld, ad, sh, bs, dn, prev_sh, done_seen;
        int          ne, nsh, nad, idx, want_edges;
        for (int i = 0; i < int'(w); i++) begin
`ifdef SKIP_ZERO_EN
            if (mult[i]) begin
                q.push_back(2'b10);
                q.push_back(2'b01);
            end else begin
                q.push_back(2'b01);
            end
`else
            q.push_back({mult[i], 1'b0});
            q.push_back(2'b01);
`endif
        end
        want_edges = (exp_edges > 0) ? exp_edges : q.size() + 1;

        mreg = mult;
        set_in(sel, 1'b1, mreg[0]);
        @(negedge Clk);
        get_out(sel, ld, ad, sh, bs, dn, cnt);
        check("idle_load", 32'(ld), 32'd1);
        check("idle_strobes", {30'd0, ad, sh}, 32'd0);
        check("idle_busy", 32'(bs), 32'd0);

        ne = 0; nsh = 0; nad = 0; idx = 0; prev_sh = 1'b0; done_seen = 1'b0;
        while (!done_seen && ne < int'(4 * w + 8)) begin
            @(posedge Clk);
            ne++;
            #1;
            if (prev_sh) mreg = mreg >> 1;
            set_in(sel, 1'b1, mreg[0]);
            @(negedge Clk);
            get_out(sel, ld, ad, sh, bs, dn, cnt);
            if (dn) begin
                done_seen = 1'b1;
            end else begin
                check("busy_high", 32'(bs), 32'd1);
                check("busy_no_load", 32'(ld), 32'd0);
                check("busy_count", cnt, 32'(nsh));
                check("strobe_seq", {30'd0, ad, sh},
                      (idx < q.size()) ? {30'd0, q[idx]} : 32'd0);
                idx++;
                nsh += int'(sh);
                nad += int'(ad);
                prev_sh = sh;
            end
        end
        check("done_reached", 32'(done_seen), 32'd1);
        check("done_edge", 32'(ne), 32'(want_edges));
        check("sh_pulses", 32'(nsh), 32'(w));
        check("ad_pulses", 32'(nad), 32'(exp_ad));
        check("done_count", cnt, 32'(w));
        check("done_not_busy", 32'(bs), 32'd0);

        for (int i = 0; i < hold; i++) begin
            @(posedge Clk);
            #1;
            @(negedge Clk);
            get_out(sel, ld, ad, sh, bs, dn, cnt);
            check("hold_done", 32'(dn), 32'd1);
            check("hold_no_load", 32'(ld), 32'd0);
            check("hold_no_strobe", {30'd0, ad, sh}, 32'd0);
        end

        set_in(sel, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        get_out(sel, ld, ad, sh, bs, dn, cnt);
        check("release_done", 32'(dn), 32'd0);
        check("release_quiet", {29'd0, ld, ad, sh}, 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        logic        ld, ad, sh, bs, dn, prev_sh;
        logic [31:0] cnt;
        logic [31:0] mreg;
        int          nsh, guard;

`ifdef SKIP_ZERO_EN
        vecs[0] = '{4'b1011, 3, 8, 0};
        vecs[1] = '{4'b0000, 0, 5, 0};
        vecs[2] = '{4'b1001, 2, 7, 5};
        vecs[3] = '{4'b1111, 4, 9, 1};
        vecs[4] = '{4'b0001, 1, 6, 0};
`else
        vecs[0] = '{4'b1011, 3, 9, 0};
        vecs[1] = '{4'b0000, 0, 9, 0};
        vecs[2] = '{4'b1001, 2, 9, 5};
        vecs[3] = '{4'b1111, 4, 9, 1};
        vecs[4] = '{4'b0001, 1, 9, 0};
`endif

        // Start high during reset must not leak a Load.
        Reset = 1'b1;
        start4 = 1'b1; m4 = 1'b1;
        start8 = 1'b0; m8 = 1'b0;
        #12;
        get_out(4, ld, ad, sh, bs, dn, cnt);
        check("reset_outputs", {27'd0, ld, ad, sh, bs, dn}, 32'd0);
        check("reset_count", cnt, 32'd0);
        start4 = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        get_out(4, ld, ad, sh, bs, dn, cnt);
        check("post_reset_idle", {27'd0, ld, ad, sh, bs, dn}, 32'd0);

        foreach (vecs[i]) begin
            run_op(4, 32'(vecs[i].mult), W4, vecs[i].exp_ad, vecs[i].exp_edges, vecs[i].hold);
        end

        // Reset during the third shift pulse of a 1011 operation.
        mreg = 32'b1011;
        set_in(4, 1'b1, mreg[0]);
        nsh = 0; prev_sh = 1'b0; guard = 0;
        while (nsh < 3 && guard < 40) begin
            @(posedge Clk);
            #1;
            if (prev_sh) mreg = mreg >> 1;
            set_in(4, 1'b1, mreg[0]);
            @(negedge Clk);
            get_out(4, ld, ad, sh, bs, dn, cnt);
            nsh += int'(sh);
            prev_sh = sh;
            guard++;
        end
        check("reached_third_shift", 32'(nsh), 32'd3);
        #1 Reset = 1'b1;
        #1;
        get_out(4, ld, ad, sh, bs, dn, cnt);
        check("midop_reset_outputs", {27'd0, ld, ad, sh, bs, dn}, 32'd0);
        check("midop_reset_count", cnt, 32'd0);
        set_in(4, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            get_out(4, ld, ad, sh, bs, dn, cnt);
            check("after_reset_quiet", {27'd0, ld, ad, sh, bs, dn}, 32'd0);
            check("after_reset_count", cnt, 32'd0);
        end

        // A new operation launches normally after the reset.
        run_op(4, 32'b0110, W4, 2, 0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] r;
            r = 32'($urandom_range(0, 255));
            run_op(8, r, W8, $countones(r[7:0]), 0, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
